// File: rtl/sfx_tone_mixer_pkg.sv
// Shared types and helpers for the sound-effect tone mixer.
// Channel FSM states, decay interval and mixer width arithmetic.
package sfx_pkg;

    typedef enum logic [0:0] {
        CH_IDLE,
        CH_PLAY
    } ch_state_e;

    // Ticks between successive one-step amplitude decrements (SFX_DECAY_EN builds).
    localparam int unsigned DECAY_TICKS = 16;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Mixer sum width: wide enough that every channel at full amplitude cannot overflow.
    function automatic int unsigned sum_width(input int unsigned amp_width,
                                              input int unsigned num_channels);
        return amp_width + clog2(num_channels);
    endfunction

endpackage

// File: rtl/sfx_tone_mixer_if.sv
// Trigger/parameter bus from game logic to the tone mixer, plus its status and audio outputs.
// master: game logic side; slave: the mixer.
interface sfx_tone_mixer_if #(
    parameter int unsigned NUM_CHANNELS   = 4,
    parameter int unsigned PERIOD_WIDTH   = 16,
    parameter int unsigned DURATION_WIDTH = 12,
    parameter int unsigned AMP_WIDTH      = 4
);

    logic [NUM_CHANNELS-1:0]                trigger;
    logic [NUM_CHANNELS*PERIOD_WIDTH-1:0]   half_period;
    logic [NUM_CHANNELS*DURATION_WIDTH-1:0] duration;
    logic [NUM_CHANNELS*AMP_WIDTH-1:0]      amplitude;
    logic [NUM_CHANNELS-1:0]                busy;
    logic                                   audio;

    modport master (
        output trigger,
        output half_period,
        output duration,
        output amplitude,
        input  busy,
        input  audio
    );

    modport slave (
        input  trigger,
        input  half_period,
        input  duration,
        input  amplitude,
        output busy,
        output audio
    );

endinterface

// File: rtl/sfx_tone_mixer_channel.sv
// One square-wave tone channel: IDLE/PLAY FSM, parameter latches, phase and duration counters.
// Optional linear amplitude decay is compiled in when SFX_DECAY_EN is defined.
module sfx_tone_channel
    import sfx_pkg::*;
#(
    parameter int unsigned PERIOD_WIDTH   = 16,
    parameter int unsigned DURATION_WIDTH = 12,
    parameter int unsigned AMP_WIDTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      tick,
    input  logic                      trigger,
    input  logic [PERIOD_WIDTH-1:0]   half_period,
    input  logic [DURATION_WIDTH-1:0] duration,
    input  logic [AMP_WIDTH-1:0]      amplitude,
    output logic [AMP_WIDTH-1:0]      level,
    output logic                      busy
);

    ch_state_e                 state_q, state_d;
    logic [PERIOD_WIDTH-1:0]   half_q, half_d;
    logic [PERIOD_WIDTH-1:0]   phase_q, phase_d;
    logic [PERIOD_WIDTH-1:0]   half_last;
    logic [DURATION_WIDTH-1:0] remain_q, remain_d;
    logic [AMP_WIDTH-1:0]      amp_q, amp_d;
    logic                      square_q, square_d;
    logic                      valid;
    logic                      load;

`ifdef SFX_DECAY_EN
    localparam int unsigned DECAY_CNT_W = clog2(DECAY_TICKS);
    logic [DECAY_CNT_W-1:0] decay_cnt_q, decay_cnt_d;
`endif

    // A zero half-period or zero duration makes the trigger a stop request, never a start.
    assign valid     = (half_period != '0) && (duration != '0);
    assign half_last = half_q - PERIOD_WIDTH'(1);

    always_comb begin
        state_d  = state_q;
        half_d   = half_q;
        phase_d  = phase_q;
        remain_d = remain_q;
        amp_d    = amp_q;
        square_d = square_q;
        load     = 1'b0;
`ifdef SFX_DECAY_EN
        decay_cnt_d = decay_cnt_q;
`endif

        unique case (state_q)
            CH_IDLE: begin
                load = trigger && valid;
            end
            CH_PLAY: begin
                if (trigger) begin
                    load = valid;
                    if (!valid) begin
                        state_d  = CH_IDLE;
                        phase_d  = '0;
                        square_d = 1'b0;
                    end
                end else begin
                    if (phase_q == half_last) begin
                        phase_d  = '0;
                        square_d = ~square_q;
                    end else begin
                        phase_d = phase_q + PERIOD_WIDTH'(1);
                    end
                    if (tick) begin
                        if (remain_q == DURATION_WIDTH'(1)) begin
                            state_d  = CH_IDLE;
                            phase_d  = '0;
                            square_d = 1'b0;
                        end else begin
                            remain_d = remain_q - DURATION_WIDTH'(1);
                        end
`ifdef SFX_DECAY_EN
                        if (decay_cnt_q == DECAY_CNT_W'(DECAY_TICKS - 1)) begin
                            decay_cnt_d = '0;
                            if (amp_q != '0) begin
                                amp_d = amp_q - AMP_WIDTH'(1);
                            end
                        end else begin
                            decay_cnt_d = decay_cnt_q + DECAY_CNT_W'(1);
                        end
`endif
                    end
                end
            end
        endcase

        // Start and retrigger share one path, so a retrigger restarts with no idle gap.
        if (load) begin
            state_d  = CH_PLAY;
            half_d   = half_period;
            remain_d = duration;
            amp_d    = amplitude;
            phase_d  = '0;
            square_d = 1'b1;
`ifdef SFX_DECAY_EN
            decay_cnt_d = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= CH_IDLE;
            half_q   <= '0;
            phase_q  <= '0;
            remain_q <= '0;
            amp_q    <= '0;
            square_q <= 1'b0;
`ifdef SFX_DECAY_EN
            decay_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            half_q   <= half_d;
            phase_q  <= phase_d;
            remain_q <= remain_d;
            amp_q    <= amp_d;
            square_q <= square_d;
`ifdef SFX_DECAY_EN
            decay_cnt_q <= decay_cnt_d;
`endif
        end
    end

    assign busy  = (state_q == CH_PLAY);
    assign level = (busy && square_q) ? amp_q : '0;

endmodule

// File: rtl/sfx_tone_mixer.sv
// Multi-channel square-wave sound-effect generator: tick prescaler, tone channels, mixer and a
// first-order sigma-delta modulator driving a 1-bit audio pin. SFX_DECAY_EN enables amplitude decay.
module sfx_tone_mixer
    import sfx_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 40000000,
    parameter int unsigned TICK_HZ        = 1000,
    parameter int unsigned NUM_CHANNELS   = 4,
    parameter int unsigned PERIOD_WIDTH   = 16,
    parameter int unsigned DURATION_WIDTH = 12,
    parameter int unsigned AMP_WIDTH      = 4
) (
    input logic              clk,
    input logic              rst_n,
    sfx_tone_mixer_if.slave  bus
);

    localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned TICK_W   = (clog2(TICK_DIV) > 0) ? clog2(TICK_DIV) : 1;
    localparam int unsigned SUM_W    = sum_width(AMP_WIDTH, NUM_CHANNELS);

    logic [TICK_W-1:0]       tick_cnt_q, tick_cnt_d;
    logic                    tick;
    logic [NUM_CHANNELS-1:0] busy;
    logic [AMP_WIDTH-1:0]    level [NUM_CHANNELS];
    logic [SUM_W-1:0]        sum_q, sum_d;
    logic [SUM_W:0]          acc_q, acc_d;

    // Free-running prescaler; the tick strobe is the cycle in which it wraps.
    assign tick       = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        sfx_tone_channel #(
            .PERIOD_WIDTH   (PERIOD_WIDTH),
            .DURATION_WIDTH (DURATION_WIDTH),
            .AMP_WIDTH      (AMP_WIDTH)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .tick        (tick),
            .trigger     (bus.trigger[i]),
            .half_period (bus.half_period[i*PERIOD_WIDTH +: PERIOD_WIDTH]),
            .duration    (bus.duration[i*DURATION_WIDTH +: DURATION_WIDTH]),
            .amplitude   (bus.amplitude[i*AMP_WIDTH +: AMP_WIDTH]),
            .level       (level[i]),
            .busy        (busy[i])
        );
    end

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            sum_d = sum_d + SUM_W'(level[i]);
        end
    end

    // Carry out of the low SUM_W bits is the output bit; its density is sum / 2^SUM_W.
    assign acc_d = {1'b0, acc_q[SUM_W-1:0]} + {1'b0, sum_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
            sum_q      <= '0;
            acc_q      <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            sum_q      <= sum_d;
            acc_q      <= acc_d;
        end
    end

    assign bus.busy  = busy;
    assign bus.audio = acc_q[SUM_W];

endmodule
